// File: rtl/alu_uart_interface.sv
// Sequencer between a UART byte stream and an external combinational ALU:
// collects operand A, operand B and op-code, then sends the ALU result back.
module alu_uart_interface #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_CODE = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NB_DATA-1:0] rx_data,
  input  logic               rx_done,
  input  logic               tx_done,
  input  logic [NB_DATA-1:0] alu_result,
  output logic [NB_DATA-1:0] dato1,
  output logic [NB_DATA-1:0] dato2,
  output logic [NB_CODE-1:0] op_code,
  output logic [NB_DATA-1:0] tx_data,
  output logic               tx_start,
  output logic               overrun
);

  typedef enum logic [2:0] {
    StWaitA,
    StWaitB,
    StWaitOp,
    StCalc,
    StSend,
    StWaitTx
  } state_e;

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] dato1_q, dato1_d;
  logic [NB_DATA-1:0] dato2_q, dato2_d;
  logic [NB_CODE-1:0] op_code_q, op_code_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               overrun_q, overrun_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StWaitA;
      dato1_q   <= '0;
      dato2_q   <= '0;
      op_code_q <= '0;
      tx_data_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dato1_q   <= dato1_d;
      dato2_q   <= dato2_d;
      op_code_q <= op_code_d;
      tx_data_q <= tx_data_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dato1_d   = dato1_q;
    dato2_d   = dato2_q;
    op_code_d = op_code_q;
    tx_data_d = tx_data_q;
    overrun_d = overrun_q;
    tx_start  = 1'b0;
    unique case (state_q)
      StWaitA: begin
        if (rx_done) begin
          dato1_d = rx_data;
          state_d = StWaitB;
        end
      end
      StWaitB: begin
        if (rx_done) begin
          dato2_d = rx_data;
          state_d = StWaitOp;
        end
      end
      StWaitOp: begin
        if (rx_done) begin
          op_code_d = rx_data[NB_CODE-1:0];
          state_d   = StCalc;
        end
      end
      // One cycle for the external ALU to settle on the new operands.
      StCalc: begin
        tx_data_d = alu_result;
        state_d   = StSend;
      end
      StSend: begin
        tx_start = 1'b1;
        state_d  = StWaitTx;
      end
      StWaitTx: begin
        if (tx_done) state_d = StWaitA;
      end
      default: state_d = StWaitA;
    endcase
    // Bytes arriving while busy are dropped but flagged.
    if (rx_done && (state_q inside {StCalc, StSend, StWaitTx})) overrun_d = 1'b1;
  end

  assign dato1   = dato1_q;
  assign dato2   = dato2_q;
  assign op_code = op_code_q;
  assign tx_data = tx_data_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Directed self-checking bench for alu_uart_interface with a small behavioural ALU.
module tb_alu_uart_interface;

  localparam int unsigned NbData = 8;
  localparam int unsigned NbCode = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic [NbData-1:0] rx_data;
  logic              rx_done;
  logic              tx_done;
  logic [NbData-1:0] alu_result;
  logic [NbData-1:0] dato1;
  logic [NbData-1:0] dato2;
  logic [NbCode-1:0] op_code;
  logic [NbData-1:0] tx_data;
  logic              tx_start;
  logic              overrun;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_uart_interface #(
    .NB_DATA(NbData),
    .NB_CODE(NbCode)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .tx_done   (tx_done),
    .alu_result(alu_result),
    .dato1     (dato1),
    .dato2     (dato2),
    .op_code   (op_code),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .overrun   (overrun)
  );

  // Team ALU: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25.
  always_comb begin
    case (op_code)
      6'h20:   alu_result = dato1 + dato2;
      6'h22:   alu_result = dato1 - dato2;
      6'h24:   alu_result = dato1 & dato2;
      6'h25:   alu_result = dato1 | dato2;
      default: alu_result = '0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  // Leaves the bench one cycle into SEND.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    send_byte(a);
    send_byte(b);
    send_byte(op);
    tick();
  endtask

  // From SEND: step into WAIT_TX and acknowledge.
  task automatic finish_tx();
    tick();
    pulse_tx_done();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({dato1, dato2, op_code, tx_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got %h %h %h %h, want 0", dato1, dato2, op_code, tx_data);
    end
    n_cmp++;
    if ({tx_start, overrun} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_flags: got tx_start=%b overrun=%b, want 0 0", tx_start, overrun);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_add();
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h20);
    n_cmp++;
    if ({dato1, dato2, op_code} !== {8'h05, 8'h03, 6'b100000}) begin
      n_bad++;
      $display("FAIL add_regs: got %h %h %h, want 05 03 20", dato1, dato2, op_code);
    end
    n_cmp++;
    if (tx_start !== 1'b0) begin
      n_bad++;
      $display("FAIL add_calc_no_start: got tx_start=%b, want 0", tx_start);
    end
    tick();
    n_cmp++;
    if (tx_start !== 1'b1 || tx_data !== 8'h08) begin
      n_bad++;
      $display("FAIL add_send: got tx_start=%b tx_data=%h, want 1 08", tx_start, tx_data);
    end
    tick();
    n_cmp++;
    if (tx_start !== 1'b0) begin
      n_bad++;
      $display("FAIL add_single_pulse: got tx_start=%b, want 0", tx_start);
    end
    pulse_tx_done();
  endtask

  task automatic test_sub_wrap();
    run_txn(8'h02, 8'h05, 8'h22);
    n_cmp++;
    if (tx_start !== 1'b1 || tx_data !== 8'hFD) begin
      n_bad++;
      $display("FAIL sub_wrap: got tx_start=%b tx_data=%h, want 1 fd", tx_start, tx_data);
    end
    finish_tx();
    send_byte(8'h11);
    n_cmp++;
    if (dato1 !== 8'h11 || dato2 !== 8'h05) begin
      n_bad++;
      $display("FAIL sub_next_a: got dato1=%h dato2=%h, want 11 05", dato1, dato2);
    end
    send_byte(8'h01);
    send_byte(8'h20);
    tick();
    n_cmp++;
    if (tx_data !== 8'h12) begin
      n_bad++;
      $display("FAIL sub_follow: got tx_data=%h, want 12", tx_data);
    end
    finish_tx();
  endtask

  task automatic test_trunc();
    run_txn(8'hF0, 8'h3C, 8'hE4);
    n_cmp++;
    if (op_code !== 6'b100100 || tx_data !== 8'h30) begin
      n_bad++;
      $display("FAIL trunc: got op_code=%h tx_data=%h, want 24 30", op_code, tx_data);
    end
    finish_tx();
  endtask

  task automatic test_overrun();
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL overrun_clear: got %b, want 0", overrun);
    end
    run_txn(8'h07, 8'h01, 8'h22);
    tick();
    send_byte(8'hAA);
    n_cmp++;
    if (overrun !== 1'b1 ||
        {dato1, dato2, op_code, tx_data} !== {8'h07, 8'h01, 6'h22, 8'h06}) begin
      n_bad++;
      $display("FAIL overrun_wait_tx: got ovr=%b %h %h %h %h, want 1 07 01 22 06",
               overrun, dato1, dato2, op_code, tx_data);
    end
    // Simultaneous rx_done and tx_done: leave WAIT_TX, drop the byte.
    rx_data = 8'h55;
    rx_done = 1'b1;
    tx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tx_done = 1'b0;
    n_cmp++;
    if (dato1 !== 8'h07) begin
      n_bad++;
      $display("FAIL both_no_capture: got dato1=%h, want 07", dato1);
    end
    send_byte(8'h09);
    n_cmp++;
    if (dato1 !== 8'h09) begin
      n_bad++;
      $display("FAIL both_back_to_a: got dato1=%h, want 09", dato1);
    end
    send_byte(8'h02);
    send_byte(8'h20);
    tick();
    n_cmp++;
    if (tx_data !== 8'h0B || overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_sticky: got tx_data=%h ovr=%b, want 0b 1", tx_data, overrun);
    end
    finish_tx();
  endtask

  task automatic test_reset_mid();
    send_byte(8'h11);
    send_byte(8'h22);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({dato1, dato2, op_code, tx_data, tx_start, overrun} !== '0) begin
      n_bad++;
      $display("FAIL reset_async: got %h %h %h %h %b %b, want all 0",
               dato1, dato2, op_code, tx_data, tx_start, overrun);
    end
    tick();
    reset = 1'b0;
    tick();
    run_txn(8'h01, 8'h01, 8'h20);
    n_cmp++;
    if (tx_data !== 8'h02 || dato1 !== 8'h01 || tx_start !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_resume: got tx_data=%h dato1=%h tx_start=%b, want 02 01 1",
               tx_data, dato1, tx_start);
    end
    finish_tx();
  endtask

  task automatic test_stray();
    bit seen_start = 1'b0;
    pulse_tx_done();
    seen_start |= tx_start;
    send_byte(8'h04);
    pulse_tx_done();
    seen_start |= tx_start;
    send_byte(8'h06);
    for (int i = 0; i < 10; i++) begin
      tick();
      seen_start |= tx_start;
    end
    n_cmp++;
    if (seen_start !== 1'b0 || dato1 !== 8'h04 || dato2 !== 8'h06) begin
      n_bad++;
      $display("FAIL stray_idle: got start_seen=%b dato1=%h dato2=%h, want 0 04 06",
               seen_start, dato1, dato2);
    end
    send_byte(8'h20);
    n_cmp++;
    if (tx_start !== 1'b0) begin
      n_bad++;
      $display("FAIL stray_calc: got tx_start=%b, want 0", tx_start);
    end
    tick();
    n_cmp++;
    if (tx_start !== 1'b1 || tx_data !== 8'h0A) begin
      n_bad++;
      $display("FAIL stray_gap_result: got tx_start=%b tx_data=%h, want 1 0a", tx_start, tx_data);
    end
    finish_tx();
  endtask

  initial begin
    reset   = 1'b1;
    rx_data = '0;
    rx_done = 1'b0;
    tx_done = 1'b0;
    test_reset();
    test_add();
    test_sub_wrap();
    test_trunc();
    test_overrun();
    test_reset_mid();
    test_stray();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
